decoded_mux: RTL and testbench

- Parameterised N-way multiplexer steered by a one-hot (already decoded) select vector.
- Selects one fixed-width way out of a flattened input bus.
- Used wherever a decoder or arbiter already produces one-hot grants, e.g. cache way selection and writeback source selection.
- Output is combinational by default; an optional registered output stage is clocked by the block clock/reset.

---
 rtl/decoded_mux_pkg.sv | 10 +
 rtl/decoded_mux_onehot_checker.sv | 30 +++
 rtl/decoded_mux.sv | 78 +++++++
 tb/tb_decoded_mux.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/decoded_mux_pkg.sv
// Shared helpers for the decoded (one-hot steered) multiplexer.
//   way_lsb : bit offset of a way inside a flattened multi-way bus.
package decoded_mux_pkg;

  // Way 0 sits in the LSBs, so way idx starts at idx * width.
  function automatic int unsigned way_lsb(input int unsigned idx, input int unsigned width);
    return idx * width;
  endfunction

endpackage

// File: rtl/decoded_mux_onehot_checker.sv
// One-hot checker for a select/grant vector.
// Ports:
//   vec_i       : vector under test
//   is_onehot_o : exactly one bit of vec_i is set
//   is_zero_o   : no bit of vec_i is set
module decoded_mux_onehot_checker #(
  parameter int unsigned NUM_WAY = 8
) (
  input  logic [NUM_WAY-1:0] vec_i,
  output logic               is_onehot_o,
  output logic               is_zero_o
);

  logic seen;
  logic multi;

  // Linear scan: 'multi' latches once a set bit follows an earlier set bit.
  always_comb begin
    seen  = 1'b0;
    multi = 1'b0;
    for (int unsigned i = 0; i < NUM_WAY; i++) begin
      multi = multi | (seen & vec_i[i]);
      seen  = seen | vec_i[i];
    end
  end

  assign is_onehot_o = seen & ~multi;
  assign is_zero_o   = ~seen;

endmodule

// File: rtl/decoded_mux.sv
// N-way AND-OR multiplexer steered by an already-decoded one-hot select.
// Ports:
//   clk_in          : clock, only used when REGISTER_OUTPUT=1
//   reset_n_in      : async active-low reset, only used when REGISTER_OUTPUT=1
//   way_flatted_in  : NUM_WAY ways of SINGLE_WAY_WIDTH_IN_BITS each, way 0 in the LSBs
//   sel_in          : one-hot select, bit i picks way i
//   way_flatted_out : selected way (OR of all selected ways if multi-hot)
//   sel_err_out     : sel_in is zero or has more than one bit set
module decoded_mux
  import decoded_mux_pkg::*;
#(
  parameter int unsigned SINGLE_WAY_WIDTH_IN_BITS = 4,
  parameter int unsigned NUM_WAY                  = 8,
  parameter int unsigned REGISTER_OUTPUT          = 0
) (
  input  logic                                        clk_in,
  input  logic                                        reset_n_in,
  input  logic [SINGLE_WAY_WIDTH_IN_BITS*NUM_WAY-1:0] way_flatted_in,
  input  logic [NUM_WAY-1:0]                          sel_in,
  output logic [SINGLE_WAY_WIDTH_IN_BITS-1:0]         way_flatted_out,
  output logic                                        sel_err_out
);

  localparam int unsigned W = SINGLE_WAY_WIDTH_IN_BITS;

  logic [W-1:0] masked [NUM_WAY];
  logic [W-1:0] mux_d;
  logic         err_d;
  logic         sel_onehot;
  logic         unused_sel_zero;

  // Each way is gated by its own select bit; multi-hot ORs the ways together.
  for (genvar g = 0; g < NUM_WAY; g++) begin : g_way
    assign masked[g] = way_flatted_in[way_lsb(g, W) +: W] & {W{sel_in[g]}};
  end

  always_comb begin
    mux_d = '0;
    for (int unsigned i = 0; i < NUM_WAY; i++) begin
      mux_d = mux_d | masked[i];
    end
  end

  decoded_mux_onehot_checker #(
    .NUM_WAY(NUM_WAY)
  ) u_onehot_checker (
    .vec_i      (sel_in),
    .is_onehot_o(sel_onehot),
    .is_zero_o  (unused_sel_zero)
  );

  assign err_d = ~sel_onehot;

  if (REGISTER_OUTPUT != 0) begin : g_reg
    logic [W-1:0] mux_q;
    logic         err_q;

    always_ff @(posedge clk_in or negedge reset_n_in) begin
      if (!reset_n_in) begin
        mux_q <= '0;
        err_q <= 1'b0;
      end else begin
        mux_q <= mux_d;
        err_q <= err_d;
      end
    end

    assign way_flatted_out = mux_q;
    assign sel_err_out     = err_q;
  end else begin : g_comb
    // Clock and reset have no load in the combinational build.
    logic unused_clk_rst;
    assign unused_clk_rst  = clk_in ^ reset_n_in;
    assign way_flatted_out = mux_d;
    assign sel_err_out     = err_d;
  end

endmodule

// File: tb/tb_decoded_mux.sv
module tb_decoded_mux;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  // Combinational 8x4 instance
  logic [31:0] c_way;
  logic [7:0]  c_sel;
  logic [3:0]  c_data;
  logic        c_err;
  // Registered 8x4 instance
  logic        r_rst_n;
  logic [31:0] r_way;
  logic [7:0]  r_sel;
  logic [3:0]  r_data;
  logic        r_err;
  // Combinational 4x32 instance
  logic [127:0] w_way;
  logic [3:0]   w_sel;
  logic [31:0]  w_data;
  logic         w_err;
  logic         tie_rst_n = 1'b1;

  decoded_mux #(
    .SINGLE_WAY_WIDTH_IN_BITS(4), .NUM_WAY(8), .REGISTER_OUTPUT(0)
  ) u_comb (
    .clk_in(clk), .reset_n_in(tie_rst_n), .way_flatted_in(c_way), .sel_in(c_sel),
    .way_flatted_out(c_data), .sel_err_out(c_err)
  );

  decoded_mux #(
    .SINGLE_WAY_WIDTH_IN_BITS(4), .NUM_WAY(8), .REGISTER_OUTPUT(1)
  ) u_reg (
    .clk_in(clk), .reset_n_in(r_rst_n), .way_flatted_in(r_way), .sel_in(r_sel),
    .way_flatted_out(r_data), .sel_err_out(r_err)
  );

  decoded_mux #(
    .SINGLE_WAY_WIDTH_IN_BITS(32), .NUM_WAY(4), .REGISTER_OUTPUT(0)
  ) u_wide (
    .clk_in(clk), .reset_n_in(tie_rst_n), .way_flatted_in(w_way), .sel_in(w_sel),
    .way_flatted_out(w_data), .sel_err_out(w_err)
  );

  typedef struct {
    int          dut;   // 0 comb, 1 registered, 2 wide
    int          due;   // cycle whose falling edge should show this value
    logic [31:0] data;
    logic        err;
    string       name;
  } exp_t;

  exp_t sb[$];
  int tests = 0;
  int fails = 0;

  task automatic push(input int dut, input int due, input logic [31:0] d, input logic e,
                      input string n);
    exp_t x;
    x.dut = dut; x.due = due; x.data = d; x.err = e; x.name = n;
    sb.push_back(x);
  endtask

  task automatic check(input exp_t x);
    logic [31:0] ad;
    logic        ae;
    case (x.dut)
      0:       begin ad = {28'h0, c_data}; ae = c_err; end
      1:       begin ad = {28'h0, r_data}; ae = r_err; end
      default: begin ad = w_data;          ae = w_err; end
    endcase
    tests++;
    if (ad !== x.data || ae !== x.err) begin
      fails++;
      $display("FAIL %s: got data=%h err=%b, expected data=%h err=%b",
               x.name, ad, ae, x.data, x.err);
    end
  endtask

  // Monitor: outputs are sampled on the falling edge, away from capture edges.
  always @(negedge clk) begin
    int i;
    i = 0;
    while (i < sb.size()) begin
      if (sb[i].due <= cycle) begin
        check(sb[i]);
        sb.delete(i);
      end else begin
        i++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] walk_exp [8];

  initial begin
    walk_exp = '{4'h4, 4'h3, 4'h2, 4'h1, 4'hd, 4'hc, 4'hb, 4'ha};
    c_way   = {4'ha, 4'hb, 4'hc, 4'hd, 4'h1, 4'h2, 4'h3, 4'h4};
    c_sel   = 8'h00;
    r_way   = {4'ha, 4'hb, 4'hc, 4'hd, 4'h1, 4'h2, 4'h3, 4'h4};
    r_sel   = 8'h80;
    r_rst_n = 1'b0;
    w_way   = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
    w_sel   = 4'b0000;

    // Combinational 8x4
    step(); c_sel = 8'b0010_0000; push(0, cycle, 32'hc, 1'b0, "simple");
    for (int i = 0; i < 8; i++) begin
      step(); c_sel = 8'h01 << i;
      push(0, cycle, {28'h0, walk_exp[i]}, 1'b0, $sformatf("walk%0d", i));
    end
    step(); c_sel = 8'h00;        push(0, cycle, 32'h0, 1'b1, "zero_sel");
    step(); c_sel = 8'b0000_0011; push(0, cycle, 32'h7, 1'b1, "multi_hot");
    step(); c_sel = 8'hff;        push(0, cycle, 32'hf, 1'b1, "all_hot");

    // Wide 4x32
    step(); w_sel = 4'b0100; push(2, cycle, 32'h3333_3333, 1'b0, "wide_sel2");
    step(); w_sel = 4'b0001; push(2, cycle, 32'h1111_1111, 1'b0, "wide_sel0");
    step(); w_sel = 4'b0000; push(2, cycle, 32'h0,         1'b1, "wide_zero");
    step(); w_sel = 4'b1010; push(2, cycle, 32'h6666_6666, 1'b1, "wide_multi");

    // Registered: held in reset with a valid select applied
    step(); push(1, cycle, 32'h0, 1'b0, "reg_in_reset");
    step(); r_rst_n = 1'b1;
    push(1, cycle,     32'h0, 1'b0, "reg_not_before");
    push(1, cycle + 1, 32'ha, 1'b0, "reg_first");
    step(); r_sel = 8'h00; push(1, cycle + 1, 32'h0, 1'b1, "reg_zero_sel");
    step(); r_sel = 8'h01;
    // Output now holds data=4; reset between edges must clear it before the next edge.
    step(); #1 r_rst_n = 1'b0; push(1, cycle, 32'h0, 1'b0, "reg_async_reset");
    step(); push(1, cycle, 32'h0, 1'b0, "reg_reset_hold");

    repeat (3) step();
    if (sb.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
